muldiv_seq: RTL and testbench
=============================

MULDIV_SEQ -- requirements
Module: muldiv_seq

Interface
REQ-001 clk  input  1  single clock; all state updates on rising edge.
REQ-002 reset  input  1  asynchronous, active-high reset.
REQ-003 startE  input  1  request a multiply/divide from the execute stage; sampled only in IDLE.
REQ-004 opE  input  2  00 MULT, 01 MULTU, 10 DIV, 11 DIVU; sampled with startE.
REQ-005 srcaE, srcbE  input  32 each  operands; srcaE is multiplicand/dividend, srcbE is multiplier/divisor; sampled with startE.
REQ-006 cancel  input  1  abort the in-flight operation (pipeline flush).
REQ-007 wehi, welo, wdata  input  1, 1, 32  direct HI/LO writes (mthi/mtlo).
REQ-008 hi, lo  output  32 each  architectural HI/LO registers.
REQ-009 busy  output  1  high while an operation is in flight; the hazard unit stalls mfhi/mflo and new mult/div on it.
REQ-010 done  output  1  registered one-cycle pulse after HI/LO are committed.
REQ-011 divz  output  1  one-cycle pulse coincident with done when a divide had srcbE=0.

Function
REQ-012 States SHALL be IDLE, PREP, CALC and FIX.
REQ-013 IDLE->PREP on the edge where startE=1 and cancel=0; operands and op are latched at that edge.
REQ-014 PREP (1 cycle): signed ops take operand magnitudes and record result signs; the 6-bit iteration counter is cleared.
REQ-015 CALC: exactly 32 cycles of radix-2 shift-add (mult) or restoring shift-subtract (div) on a 64-bit working register; the counter increments each cycle and leaves at count 31.
REQ-016 FIX (1 cycle): apply sign correction and commit HI/LO at the exiting edge; next state is IDLE; done=1 in the following cycle.
REQ-017 Latency: with the start edge as E0, HI/LO update at edge E34 and done is high during the cycle after E34.
REQ-018 busy=1 in PREP, CALC and FIX.
REQ-019 MULT/MULTU: {hi,lo} is the 64-bit product; signed product is the two's complement of the magnitude product when operand signs differ.
REQ-020 DIV/DIVU: lo=quotient, hi=remainder; signed quotient is negative iff operand signs differ; remainder takes the dividend's sign.
REQ-021 Divide by zero: lo=0xFFFFFFFF, hi=srcaE as latched, divz pulses with done, latency unchanged.
REQ-022 DIV 0x80000000 / 0xFFFFFFFF: lo=0x80000000, hi=0, no exception.
REQ-023 cancel=1 while busy: return to IDLE at the next edge; HI/LO unchanged; no done pulse.
REQ-024 cancel=1 together with startE in IDLE: the start is ignored.
REQ-025 startE while busy: ignored; no queuing.
REQ-026 wehi/welo in IDLE: write wdata to HI/LO at the edge.
REQ-027 wehi/welo while busy: ignored.
REQ-028 wehi/welo together with startE in IDLE: the write takes effect, and the later commit overwrites it.

Reset
REQ-029 reset asserted SHALL immediately force: state=IDLE, hi=0, lo=0, busy=0, done=0, divz=0, counter=0.
REQ-030 Reset mid-operation SHALL discard the operation with no done pulse.

Structure
REQ-031 Shared package muldiv_pkg SHALL hold the op encoding enum, the state enum and the constant ITER=32.
REQ-032 One sub-module, muldiv_step, SHALL implement a single combinational iteration (add-shift or subtract-shift) selected by op class.
REQ-033 Sign fix-up and control stay in muldiv_seq.

Verification
REQ-034 MULT 0xFFFFFFFF x 0x00000002 -> hi=0xFFFFFFFF, lo=0xFFFFFFFE at E34; done at E34+1.
REQ-035 MULTU 0xFFFFFFFF x 0x00000002 -> hi=0x00000001, lo=0xFFFFFFFE.
REQ-036 DIV 0xFFFFFFF9 (-7) / 2 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF; DIV 0x80000000 / 0xFFFFFFFF -> lo=0x80000000, hi=0.
REQ-037 DIVU 0x64 / 0 -> lo=0xFFFFFFFF, hi=0x64, divz and done pulse together.
REQ-038 Preload hi=0x11 via wehi, start MULTU 3x4, cancel at cycle 10 -> hi=0x11 and lo unchanged, busy low after the next edge, no done; repeat with reset at cycle 10 -> hi=lo=0.
REQ-039 startE and a second startE during busy -> only the first result is committed; mthi during busy is ignored.

Source files
------------

// File: rtl/muldiv_pkg.sv
// Shared types and constants for the sequential multiply/divide unit.
package muldiv_pkg;

  // Operation encoding as presented on opE.
  typedef enum logic [1:0] {
    OpMult  = 2'b00,
    OpMultu = 2'b01,
    OpDiv   = 2'b10,
    OpDivu  = 2'b11
  } opT;

  typedef enum logic [1:0] {
    StIdle = 2'b00,
    StPrep = 2'b01,
    StCalc = 2'b10,
    StFix  = 2'b11
  } stateT;

  // Number of CALC iterations (one result bit per cycle).
  localparam int unsigned ITER = 32;

  // Magnitude of a 32-bit value; only signed ops take the absolute value.
  function automatic logic [31:0] absVal(input logic [31:0] v, input logic signedOp);
    return (signedOp && v[31]) ? (~v + 32'd1) : v;
  endfunction

endpackage

// File: rtl/muldiv_if.sv
// Execute-stage <-> multiply/divide unit signal bundle.
interface muldiv_if;

  logic        startE;
  logic [1:0]  opE;
  logic [31:0] srcaE;
  logic [31:0] srcbE;
  logic        cancel;
  logic        wehi;
  logic        welo;
  logic [31:0] wdata;
  logic [31:0] hi;
  logic [31:0] lo;
  logic        busy;
  logic        done;
  logic        divz;

  modport master (
    output startE, opE, srcaE, srcbE, cancel, wehi, welo, wdata,
    input  hi, lo, busy, done, divz
  );

  modport slave (
    input  startE, opE, srcaE, srcbE, cancel, wehi, welo, wdata,
    output hi, lo, busy, done, divz
  );

endinterface

// File: rtl/muldiv_step.sv
// One radix-2 iteration on the 64-bit working register.
// Multiply: work = {partial, multiplier}; add opnd to the top half when bit 0 is set, shift right.
// Divide:   work = {remainder, dividend}; shift left, subtract opnd if it fits, shift in the bit.
module muldiv_step (
  input  logic        isDiv,
  input  logic [63:0] work,
  input  logic [31:0] opnd,
  output logic [63:0] workNext
);

  logic [32:0] sum;
  logic [32:0] sh;
  logic        fits;
  logic [31:0] remSub;

  assign sum    = {1'b0, work[63:32]} + (work[0] ? {1'b0, opnd} : 33'd0);
  assign sh     = {work[63:32], work[31]};
  assign fits   = (sh >= {1'b0, opnd});
  // The true difference is below 2^32 whenever it fits, so 32 bits suffice.
  assign remSub = sh[31:0] - opnd;

  // Select the add-shift or subtract-shift result by op class.
  always_comb begin
    workNext = {sum, work[31:1]};
    if (isDiv) begin
      workNext = fits ? {remSub, work[30:0], 1'b1} : {sh[31:0], work[30:0], 1'b0};
    end
  end

endmodule

// File: rtl/muldiv_seq.sv
// Sequential 32x32 multiply / 32/32 divide unit with architectural HI/LO.
// IDLE -> PREP (magnitudes, signs) -> CALC (32 iterations) -> FIX (sign fix, commit) -> IDLE.
module muldiv_seq
  import muldiv_pkg::*;
(
  input  logic     clk,
  input  logic     reset,
  muldiv_if.slave  bus
);

  stateT       stateQ, stateD;
  opT          opQ;
  logic [31:0] srcaQ, srcbQ, opndQ;
  logic [63:0] workQ, workStep;
  logic [5:0]  cntQ;
  logic        negResQ, negRemQ;
  logic [31:0] hiQ, loQ;
  logic        doneQ, divzQ;

  logic        startOk, isDiv, isSigned, divZero;
  logic [63:0] prod;
  logic [31:0] quo, rem, fixHi, fixLo;

  assign startOk  = bus.startE && !bus.cancel;
  assign isDiv    = (opQ == OpDiv) || (opQ == OpDivu);
  assign isSigned = (opQ == OpMult) || (opQ == OpDiv);
  assign divZero  = isDiv && (srcbQ == 32'd0);

  muldiv_step uStep (
    .isDiv    (isDiv),
    .work     (workQ),
    .opnd     (opndQ),
    .workNext (workStep)
  );

  // State register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) stateQ <= StIdle;
    else       stateQ <= stateD;
  end

  // Next-state logic; cancel aborts from any busy state.
  always_comb begin
    stateD = stateQ;
    case (stateQ)
      StIdle:  if (startOk) stateD = StPrep;
      StPrep:  stateD = bus.cancel ? StIdle : StCalc;
      StCalc: begin
        if (bus.cancel)                   stateD = StIdle;
        else if (cntQ == 6'(ITER - 1))    stateD = StFix;
      end
      StFix:   stateD = StIdle;
      default: stateD = StIdle;
    endcase
  end

  // Sign correction of the magnitude result; divide-by-zero bypasses it.
  always_comb begin
    prod  = negResQ ? (~workQ + 64'd1) : workQ;
    quo   = negResQ ? (~workQ[31:0] + 32'd1) : workQ[31:0];
    rem   = negRemQ ? (~workQ[63:32] + 32'd1) : workQ[63:32];
    fixHi = prod[63:32];
    fixLo = prod[31:0];
    if (divZero) begin
      fixHi = srcaQ;
      fixLo = 32'hFFFF_FFFF;
    end else if (isDiv) begin
      fixHi = rem;
      fixLo = quo;
    end
  end

  // Datapath, HI/LO and the registered done/divz pulses.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      opQ     <= OpMult;
      srcaQ   <= '0;
      srcbQ   <= '0;
      opndQ   <= '0;
      workQ   <= '0;
      cntQ    <= '0;
      negResQ <= 1'b0;
      negRemQ <= 1'b0;
      hiQ     <= '0;
      loQ     <= '0;
      doneQ   <= 1'b0;
      divzQ   <= 1'b0;
    end else begin
      doneQ <= 1'b0;
      divzQ <= 1'b0;
      case (stateQ)
        StIdle: begin
          if (bus.wehi) hiQ <= bus.wdata;
          if (bus.welo) loQ <= bus.wdata;
          if (startOk) begin
            opQ   <= opT'(bus.opE);
            srcaQ <= bus.srcaE;
            srcbQ <= bus.srcbE;
          end
        end
        StPrep: begin
          cntQ    <= '0;
          negResQ <= isSigned && (srcaQ[31] ^ srcbQ[31]);
          negRemQ <= isSigned && srcaQ[31];
          workQ   <= {32'd0, isDiv ? absVal(srcaQ, isSigned) : absVal(srcbQ, isSigned)};
          opndQ   <= isDiv ? absVal(srcbQ, isSigned) : absVal(srcaQ, isSigned);
        end
        StCalc: begin
          workQ <= workStep;
          cntQ  <= cntQ + 6'd1;
        end
        StFix: begin
          if (!bus.cancel) begin
            hiQ   <= fixHi;
            loQ   <= fixLo;
            doneQ <= 1'b1;
            divzQ <= divZero;
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.hi   = hiQ;
  assign bus.lo   = loQ;
  assign bus.busy = (stateQ != StIdle);
  assign bus.done = doneQ;
  assign bus.divz = divzQ;

endmodule

// File: tb/tb_muldiv_seq.sv
// Scoreboard bench for muldiv_seq: stimulus pushes expected HI/LO/divz and the
// expected done cycle; a negedge monitor pops and compares on every done pulse.
module tb_muldiv_seq;
  import muldiv_pkg::*;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  muldiv_if bus ();

  muldiv_seq dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  typedef struct {
    logic [31:0] hi;
    logic [31:0] lo;
    logic        divz;
    int          cyc;
  } expT;

  expT sb[$];
  int  cyc  = 0;
  int  nVec = 0;
  int  nErr = 0;
  logic [31:0] mLo;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    nVec++;
    if (act !== exp) begin
      nErr++;
      $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: every done pulse must match the oldest outstanding expectation.
  always @(negedge clk) begin
    expT e;
    if (!reset && bus.divz && !bus.done) begin
      nVec++;
      nErr++;
      $display("FAIL divz_without_done: got divz=1 done=0, expected divz only with done");
    end
    if (!reset && bus.done) begin
      if (sb.size() == 0) begin
        nVec++;
        nErr++;
        $display("FAIL unexpected_done: got done=1, expected 0 (cycle %0d)", cyc);
      end else begin
        e = sb.pop_front();
        check("result_hi", bus.hi, e.hi);
        check("result_lo", bus.lo, e.lo);
        check("result_divz", {31'd0, bus.divz}, {31'd0, e.divz});
        check("done_cycle", 32'(cyc), 32'(e.cyc));
      end
    end
  end

  task automatic issue(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                       output int c0);
    @(negedge clk);
    bus.startE = 1'b1;
    bus.opE    = op;
    bus.srcaE  = a;
    bus.srcbE  = b;
    @(posedge clk);
    #1;
    c0         = cyc;
    bus.startE = 1'b0;
  endtask

  task automatic startOp(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] eh, input logic [31:0] el, input logic ez);
    int c0;
    issue(op, a, b, c0);
    sb.push_back('{hi: eh, lo: el, divz: ez, cyc: c0 + 34});
    mLo = el;
  endtask

  task automatic waitDone();
    int n = 0;
    while (sb.size() != 0 && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (sb.size() != 0) begin
      nVec++;
      nErr++;
      $display("FAIL done_timeout: got no done in 100 cycles, expected %0d result(s)",
               sb.size());
      sb.delete();
    end
    @(negedge clk);
  endtask

  task automatic mtWrite(input logic h, input logic l, input logic [31:0] d);
    @(negedge clk);
    bus.wehi  = h;
    bus.welo  = l;
    bus.wdata = d;
    @(posedge clk);
    #1;
    bus.wehi = 1'b0;
    bus.welo = 1'b0;
  endtask

  initial begin
    int c0;
    bus.startE = 1'b0;
    bus.opE    = 2'b00;
    bus.srcaE  = '0;
    bus.srcbE  = '0;
    bus.cancel = 1'b0;
    bus.wehi   = 1'b0;
    bus.welo   = 1'b0;
    bus.wdata  = '0;

    // Reset state.
    repeat (2) @(negedge clk);
    check("reset_hi", bus.hi, 32'h0);
    check("reset_lo", bus.lo, 32'h0);
    check("reset_busy", {31'd0, bus.busy}, 32'd0);
    check("reset_done", {31'd0, bus.done}, 32'd0);
    check("reset_divz", {31'd0, bus.divz}, 32'd0);
    reset = 1'b0;

    // Direct HI/LO writes in IDLE.
    mtWrite(1'b1, 1'b0, 32'h11);
    check("mthi", bus.hi, 32'h11);
    mtWrite(1'b0, 1'b1, 32'h22);
    check("mtlo", bus.lo, 32'h22);
    check("mthi_kept", bus.hi, 32'h11);

    // Directed multiply/divide vectors.
    startOp(2'b00, 32'hFFFF_FFFF, 32'h2, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 1'b0); waitDone();
    startOp(2'b01, 32'hFFFF_FFFF, 32'h2, 32'h0000_0001, 32'hFFFF_FFFE, 1'b0); waitDone();
    startOp(2'b00, 32'hFFFF_FFFD, 32'h5, 32'hFFFF_FFFF, 32'hFFFF_FFF1, 1'b0); waitDone();
    startOp(2'b01, 32'h0001_0000, 32'h0001_0000, 32'h1, 32'h0, 1'b0);       waitDone();
    startOp(2'b10, 32'hFFFF_FFF9, 32'h2, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 1'b0); waitDone();
    startOp(2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0, 32'h8000_0000, 1'b0); waitDone();
    startOp(2'b10, 32'h7, 32'hFFFF_FFFE, 32'h1, 32'hFFFF_FFFD, 1'b0);        waitDone();
    startOp(2'b11, 32'h64, 32'h7, 32'h2, 32'hE, 1'b0);                         waitDone();
    startOp(2'b11, 32'h64, 32'h0, 32'h64, 32'hFFFF_FFFF, 1'b1);                waitDone();
    startOp(2'b10, 32'hFFFF_FFF8, 32'h0, 32'hFFFF_FFF8, 32'hFFFF_FFFF, 1'b1);  waitDone();

    // Start together with cancel in IDLE is ignored.
    @(negedge clk);
    bus.startE = 1'b1;
    bus.cancel = 1'b1;
    bus.opE    = 2'b01;
    @(posedge clk);
    #1;
    bus.startE = 1'b0;
    bus.cancel = 1'b0;
    check("start_with_cancel_busy", {31'd0, bus.busy}, 32'd0);

    // Write together with start: write lands now, commit overwrites later.
    @(negedge clk);
    bus.wehi   = 1'b1;
    bus.wdata  = 32'hAB;
    bus.startE = 1'b1;
    bus.opE    = 2'b01;
    bus.srcaE  = 32'd5;
    bus.srcbE  = 32'd6;
    @(posedge clk);
    #1;
    c0 = cyc;
    bus.wehi   = 1'b0;
    bus.startE = 1'b0;
    sb.push_back('{hi: 32'h0, lo: 32'd30, divz: 1'b0, cyc: c0 + 34});
    mLo = 32'd30;
    check("write_with_start_hi", bus.hi, 32'hAB);
    check("write_with_start_busy", {31'd0, bus.busy}, 32'd1);
    waitDone();

    // Cancel mid-operation: HI/LO untouched, no done.
    mtWrite(1'b1, 1'b0, 32'h11);
    issue(2'b01, 32'd3, 32'd4, c0);
    repeat (9) @(negedge clk);
    bus.cancel = 1'b1;
    @(posedge clk);
    #1;
    bus.cancel = 1'b0;
    check("cancel_busy", {31'd0, bus.busy}, 32'd0);
    check("cancel_hi", bus.hi, 32'h11);
    check("cancel_lo", bus.lo, mLo);
    repeat (40) @(negedge clk);
    check("cancel_hi_later", bus.hi, 32'h11);

    // Reset mid-operation: immediate clear, no done.
    issue(2'b01, 32'd3, 32'd4, c0);
    repeat (9) @(negedge clk);
    reset = 1'b1;
    #1;
    check("midreset_hi", bus.hi, 32'h0);
    check("midreset_lo", bus.lo, 32'h0);
    check("midreset_busy", {31'd0, bus.busy}, 32'd0);
    @(negedge clk);
    reset = 1'b0;
    repeat (40) @(negedge clk);

    // Second start and mthi while busy are both ignored.
    startOp(2'b00, 32'd3, 32'd4, 32'h0, 32'hC, 1'b0);
    repeat (4) @(negedge clk);
    check("busy_in_calc", {31'd0, bus.busy}, 32'd1);
    bus.startE = 1'b1;
    bus.opE    = 2'b11;
    bus.srcaE  = 32'd100;
    bus.srcbE  = 32'd5;
    bus.wehi   = 1'b1;
    bus.wdata  = 32'h55;
    @(posedge clk);
    #1;
    bus.startE = 1'b0;
    bus.wehi   = 1'b0;
    check("mthi_while_busy", bus.hi, 32'h0);
    waitDone();
    repeat (40) @(negedge clk);
    check("final_hi", bus.hi, 32'h0);
    check("final_lo", bus.lo, 32'hC);

    $display("== %0d vectors applied, %0d miscompares ==", nVec, nErr);
    $finish;
  end

endmodule
